// File: rtl/adder_pipe.sv
// adder_pipe: pipelined WIDTH-bit adder, one CHUNK-bit slice per stage.
// Define ADDER_PIPE_SUB_EN to add a sub port computing a - b - cin.
module adder_pipe #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADDER_PIPE_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   localparam int CSAFE  = (CHUNK < 1) ? 1 : CHUNK;
   localparam int STAGES = (WIDTH / CSAFE < 1) ? 1 : WIDTH / CSAFE;

   if (CHUNK < 1 || (WIDTH % CSAFE) != 0 || WIDTH < CSAFE) begin : g_bad
      $error("adder_pipe: WIDTH must be a positive multiple of CHUNK");
   end

   logic [WIDTH-1:0] b_in;
   logic             c_in;

`ifdef ADDER_PIPE_SUB_EN
   // subtract as a + ~b + !cin so cout reads as "no borrow"
   assign b_in = sub ? ~b : b;
   assign c_in = sub ? ~cin : cin;
`else
   assign b_in = b;
   assign c_in = cin;
`endif

   logic [STAGES-1:0] vld_q, cy_q, vld_d, cy_d;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic              advance;

   logic [WIDTH-1:0]  ai, bi, si;
   logic              ci, vi;
   logic [CSAFE:0]    t;

   assign advance  = !vld_q[STAGES-1] || out_ready;
   assign in_ready = advance;

   always_comb begin
      ai    = '0;
      bi    = '0;
      si    = '0;
      ci    = 1'b0;
      vi    = 1'b0;
      t     = '0;
      vld_d = '0;
      cy_d  = '0;
      for (int k = 0; k < STAGES; k++) begin
         a_d[k] = '0;
         b_d[k] = '0;
         s_d[k] = '0;
      end
      for (int k = 0; k < STAGES; k++) begin
         int p;
         p = (k == 0) ? 0 : k - 1;
         if (k == 0) begin
            ai = a;
            bi = b_in;
            ci = c_in;
            si = '0;
            vi = in_valid;
         end else begin
            ai = a_q[p];
            bi = b_q[p];
            ci = cy_q[p];
            si = s_q[p];
            vi = vld_q[p];
         end
         t = {1'b0, ai[k*CSAFE +: CSAFE]}
           + {1'b0, bi[k*CSAFE +: CSAFE]}
           + {{CSAFE{1'b0}}, ci};
         si[k*CSAFE +: CSAFE] = t[CSAFE-1:0];
         a_d[k]   = ai;
         b_d[k]   = bi;
         s_d[k]   = si;
         cy_d[k]  = t[CSAFE];
         vld_d[k] = vi;
      end
   end

   // the whole pipe moves or holds as one
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         cy_q  <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (advance) begin
         vld_q <= vld_d;
         cy_q  <= cy_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
         end
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign s         = s_q[STAGES-1];
   assign cout      = cy_q[STAGES-1];

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed checks of adder_pipe (WIDTH=16, CHUNK=4).
// Covers latency, carry chains, streaming, backpressure and reset.
module tb_adder_pipe;

   localparam int W = 16;
   localparam int STG = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         cout;
`ifdef ADDER_PIPE_SUB_EN
   logic         sub;
`endif

   int npass = 0;
   int ntot  = 0;

   logic [W-1:0] va [8];
   logic [W-1:0] vb [8];
   logic         vc [8];
   logic         vv [8];
   logic         vs [8];
   logic [W-1:0] es [8];
   logic         ec [8];

   adder_pipe #(.WIDTH(16), .CHUNK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef ADDER_PIPE_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic setv(input int i, input logic v, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic c,
                       input logic [W-1:0] rs, input logic rc);
      vv[i] = v;
      va[i] = x;
      vb[i] = y;
      vc[i] = c;
      vs[i] = 1'b0;
      es[i] = rs;
      ec[i] = rc;
   endtask

   // drive n slots back-to-back and expect each one exactly STG cycles later
   task automatic stream(input string tag, input int n);
      for (int j = 0; j < n + STG; j++) begin
         int o;
         if (j < n) begin
            in_valid = vv[j];
            a        = va[j];
            b        = vb[j];
            cin      = vc[j];
`ifdef ADDER_PIPE_SUB_EN
            sub      = vs[j];
`endif
         end else begin
            in_valid = 1'b0;
         end
         tick();
         o = j + 1 - STG;
         if (o >= 0 && o < n) begin
            check($sformatf("%s_v%0d", tag, o), 32'(out_valid), 32'(vv[o]));
            if (vv[o]) begin
               check($sformatf("%s_s%0d", tag, o), 32'(s), 32'(es[o]));
               check($sformatf("%s_c%0d", tag, o), 32'(cout), 32'(ec[o]));
            end
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      out_ready = 1'b1;
`ifdef ADDER_PIPE_SUB_EN
      sub       = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b0;
      check("rst_ov", 32'(out_valid), 32'd0);
      check("rst_s", 32'(s), 32'h0000);
      check("rst_c", 32'(cout), 32'd0);
      check("rst_ir", 32'(in_ready), 32'd1);

      // single op latency
      in_valid = 1'b1;
      a = 16'h0001;
      b = 16'h0001;
      cin = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("lat_early", 32'(out_valid), 32'd0);
      tick();
      check("lat_ov", 32'(out_valid), 32'd1);
      check("lat_s", 32'(s), 32'h0002);
      check("lat_c", 32'(cout), 32'd0);
      tick();
      check("lat_drain", 32'(out_valid), 32'd0);

      // carry rippling through every stage
      setv(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      setv(1, 1'b1, 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1);
      setv(2, 1'b1, 16'h8001, 16'h8001, 1'b0, 16'h0002, 1'b1);
      stream("carry", 3);

      // streaming with a bubble
      setv(0, 1'b1, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
      setv(1, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 16'h0000, 1'b0);
      setv(2, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
      setv(3, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
      setv(4, 1'b1, 16'hABCD, 16'h5432, 1'b1, 16'h0000, 1'b1);
      setv(5, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
      setv(6, 1'b1, 16'h1000, 16'h2000, 1'b0, 16'h3000, 1'b0);
      stream("strm", 7);

      // backpressure: fill 4 ops, stall 5 cycles, release
      setv(0, 1'b1, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
      setv(1, 1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
      setv(2, 1'b1, 16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1);
      setv(3, 1'b1, 16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         a = va[i];
         b = vb[i];
         cin = vc[i];
         tick();
      end
      in_valid = 1'b1;
      a = 16'h5555;
      b = 16'h5555;
      cin = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_ir%0d", i), 32'(in_ready), 32'd0);
         check($sformatf("bp_ov%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("bp_s%0d", i), 32'(s), 32'(es[0]));
         check($sformatf("bp_c%0d", i), 32'(cout), 32'(ec[0]));
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rel_v%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("rel_s%0d", i), 32'(s), 32'(es[i]));
         check($sformatf("rel_c%0d", i), 32'(cout), 32'(ec[i]));
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rel_empty%0d", i), 32'(out_valid), 32'd0);
         tick();
      end

      // reset with ops in flight
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         a = 16'h0100 + 16'(i);
         b = 16'h0010;
         cin = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_ov", 32'(out_valid), 32'd0);
      check("mrst_s", 32'(s), 32'h0000);
      check("mrst_c", 32'(cout), 32'd0);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("mrst_stale%0d", i), 32'(out_valid), 32'd0);
         tick();
      end

`ifdef ADDER_PIPE_SUB_EN
      setv(0, 1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
      vs[0] = 1'b1;
      setv(1, 1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
      vs[1] = 1'b1;
      setv(2, 1'b1, 16'h0007, 16'h0005, 1'b1, 16'h000D, 1'b0);
      stream("sub", 3);
      sub = 1'b0;
`endif

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
